uop_issue_arbiter: RTL

- Feeds the uop execute stage (`uop_executing`) from two uop sources: the main decoder (source 0) and the scheduler (source 1).
- Buffers each source in a small FIFO and picks one uop per cycle, round-robin.
- Honours chained (multi-uop) sequences and re-presents the in-flight uop while the memory unit stalls.
- Drives `uop_next`, `temp_a`, `temp_b`, `next_main`, `next_sched` and `stop` of the execute stage.

---
 rtl/uop_pkg.sv | 18 +
 rtl/uop_issue_arbiter_if.sv | 34 +++
 rtl/uop_fifo.sv | 46 ++++
 rtl/uop_issue_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/uop_pkg.sv
// Shared uop constants, bit positions and source encoding for the issue arbiter.
package uop_pkg;

  localparam int unsigned UOP_W = 20;
  localparam int unsigned T_W   = 16;

  localparam logic [UOP_W-1:0] UOP_NOP = 20'h00A00;

  localparam int unsigned UOP_CHAIN_BIT = 7;
  localparam int unsigned UOP_MEM_A_BIT = 13;
  localparam int unsigned UOP_MEM_B_BIT = 14;

  typedef enum logic {
    SRC_MAIN  = 1'b0,
    SRC_SCHED = 1'b1
  } src_e;

endpackage

// File: rtl/uop_issue_arbiter_if.sv
// Source push channels and execute-stage outputs of the uop issue arbiter.
interface uop_issue_arbiter_if
  import uop_pkg::*;
#(
  parameter int unsigned UOP_W = uop_pkg::UOP_W,
  parameter int unsigned T_W   = uop_pkg::T_W
);
  logic             s0_valid;
  logic             s0_ready;
  logic [UOP_W-1:0] s0_uop;
  logic [T_W-1:0]   s0_temp;
  logic             s1_valid;
  logic             s1_ready;
  logic [UOP_W-1:0] s1_uop;
  logic [T_W-1:0]   s1_temp;
  logic             mem_busy;
  logic [UOP_W-1:0] uop_next;
  logic [T_W-1:0]   temp_a;
  logic [T_W-1:0]   temp_b;
  logic             next_main;
  logic             next_sched;
  logic             stop;

  modport master (
    output s0_valid, s0_uop, s0_temp, s1_valid, s1_uop, s1_temp, mem_busy,
    input  s0_ready, s1_ready, uop_next, temp_a, temp_b, next_main, next_sched, stop
  );

  modport slave (
    input  s0_valid, s0_uop, s0_temp, s1_valid, s1_uop, s1_temp, mem_busy,
    output s0_ready, s1_ready, uop_next, temp_a, temp_b, next_main, next_sched, stop
  );

endinterface

// File: rtl/uop_fifo.sv
// Per-source uop FIFO; head entry is combinationally visible, push is refused when full.
module uop_fifo
  import uop_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = UOP_W + T_W
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uop_issue_arbiter.sv
// Round-robin issue of main/scheduler uops into the execute stage, with chain lock
// and re-presentation of the in-flight uop while the memory unit stalls.
module uop_issue_arbiter
  import uop_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned UOP_W = uop_pkg::UOP_W,
  parameter int unsigned T_W   = uop_pkg::T_W
) (
  input logic                clk,
  input logic                a_rst,
  uop_issue_arbiter_if.slave bus
);
  localparam int unsigned EW = UOP_W + T_W;

  logic [EW-1:0] head [2];
  logic [1:0]    full, empty, pop;

  src_e             rr_q, rr_d;
  logic             lock_valid_q, lock_valid_d;
  src_e             lock_src_q, lock_src_d;
  logic [UOP_W-1:0] sh_uop_q;
  logic [T_W-1:0]   sh_temp_q;
  src_e             sh_src_q;
  logic             sh_valid_q;

  logic             stop, grant;
  src_e             gnt_src;
  logic [UOP_W-1:0] iss_uop;
  logic [T_W-1:0]   iss_temp;

  assign bus.s0_ready = ~full[0];
  assign bus.s1_ready = ~full[1];

  uop_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo_main (
    .clk       (clk),
    .a_rst     (a_rst),
    .push      (bus.s0_valid),
    .push_data ({bus.s0_uop, bus.s0_temp}),
    .pop       (pop[0]),
    .head      (head[0]),
    .full      (full[0]),
    .empty     (empty[0])
  );

  uop_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo_sched (
    .clk       (clk),
    .a_rst     (a_rst),
    .push      (bus.s1_valid),
    .push_data ({bus.s1_uop, bus.s1_temp}),
    .pop       (pop[1]),
    .head      (head[1]),
    .full      (full[1]),
    .empty     (empty[1])
  );

  always_comb begin
    grant        = 1'b0;
    gnt_src      = SRC_MAIN;
    rr_d         = rr_q;
    lock_valid_d = lock_valid_q;
    lock_src_d   = lock_src_q;
    pop          = '0;
    iss_uop      = UOP_W'(UOP_NOP);
    iss_temp     = '0;
    stop = sh_valid_q & (sh_uop_q[UOP_MEM_A_BIT] | sh_uop_q[UOP_MEM_B_BIT]) & bus.mem_busy;

    if (!stop) begin
      // A locked chain owns the issue slot even when its FIFO has run dry.
      if (lock_valid_q) begin
        grant   = ~empty[lock_src_q];
        gnt_src = lock_src_q;
      end else if (!empty[0] && !empty[1]) begin
        grant   = 1'b1;
        gnt_src = rr_q;
        rr_d    = (rr_q == SRC_MAIN) ? SRC_SCHED : SRC_MAIN;
      end else if (!empty[0]) begin
        grant   = 1'b1;
        gnt_src = SRC_MAIN;
      end else if (!empty[1]) begin
        grant   = 1'b1;
        gnt_src = SRC_SCHED;
      end

      if (grant) begin
        pop[gnt_src]        = 1'b1;
        {iss_uop, iss_temp} = head[gnt_src];
        if (iss_uop[UOP_CHAIN_BIT]) begin
          lock_valid_d = 1'b1;
          lock_src_d   = gnt_src;
        end else begin
          lock_valid_d = 1'b0;
        end
      end
    end

    if (stop) begin
      bus.uop_next   = sh_uop_q;
      bus.temp_a     = sh_temp_q;
      bus.temp_b     = sh_temp_q;
      bus.next_main  = (sh_src_q == SRC_MAIN);
      bus.next_sched = (sh_src_q == SRC_SCHED);
    end else begin
      bus.uop_next   = iss_uop;
      bus.temp_a     = iss_temp;
      bus.temp_b     = iss_temp;
      bus.next_main  = grant & (gnt_src == SRC_MAIN);
      bus.next_sched = grant & (gnt_src == SRC_SCHED);
    end
    bus.stop = stop;
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rr_q         <= SRC_MAIN;
      lock_valid_q <= 1'b0;
      lock_src_q   <= SRC_MAIN;
      sh_uop_q     <= UOP_W'(UOP_NOP);
      sh_temp_q    <= '0;
      sh_src_q     <= SRC_MAIN;
      sh_valid_q   <= 1'b0;
    end else if (!stop) begin
      rr_q         <= rr_d;
      lock_valid_q <= lock_valid_d;
      lock_src_q   <= lock_src_d;
      sh_uop_q     <= iss_uop;
      sh_temp_q    <= iss_temp;
      sh_src_q     <= grant ? gnt_src : SRC_MAIN;
      sh_valid_q   <= grant;
    end
  end

endmodule
